// File: rtl/slave_wait_responder_if.sv
// Slave-side crossbar bus: a request/command from the master, and ack, read data and error from the slave.
interface slave_wait_responder_if;
  logic        req;
  logic        cmd;
  logic [30:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, cmd, addr, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, cmd, addr, wdata,
    output ack, rdata, err
  );
endinterface

// File: rtl/slave_wait_responder.sv
// Purpose: memory-backed crossbar slave that inserts WAIT_CYCLES wait states and flags out-of-range accesses.
// Latency: ack after WAIT_CYCLES+1 cycles of req; rdata and err are registered and appear the cycle after ack.
// Backpressure: req is held until ack; dropping req early abandons the request with no state change.
module slave_wait_responder #(
  parameter int          AW          = 4,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  slave_wait_responder_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam int WW    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_CYCLES);

  logic [31:0]   mem [0:DEPTH-1];
  logic [WW-1:0] wcnt;
  logic          accept;
  logic          in_range;
  logic [AW-1:0] index;

  assign index    = bus.addr[AW-1:0];
  assign in_range = (bus.addr >> AW) == 31'd0;
  assign accept   = bus.req & ~rst & (wcnt == WAIT_MAX);
  assign bus.ack  = accept;

  // Counter restarts after each acceptance so a held req waits again.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (!bus.req || accept) begin
      wcnt <= '0;
    end else if (wcnt < WAIT_MAX) begin
      wcnt <= wcnt + 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept && bus.cmd && in_range) begin
      mem[index] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata <= '0;
    end else if (accept && !bus.cmd) begin
      bus.rdata <= in_range ? mem[index] : ERR_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err <= 1'b0;
    end else begin
      bus.err <= accept & ~in_range;
    end
  end
endmodule
